// File: rtl/riscv_i32_ifetch_mem_adapter_pkg.sv
// Shared fetch types for the memory-side instruction fetch adapter.
package riscv_i32_ifetch_mem_adapter_pkg;

  localparam int RISCV_FETCH_TAG_W = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic        sequential;
    logic [2:0]  mode;
    logic        flush;
  } t_riscv_fetch_req;

  typedef struct packed {
    logic                         valid;
    logic                         debug;
    logic [31:0]                  data;
    logic [2:0]                   mode;
    logic                         error;
    logic [RISCV_FETCH_TAG_W-1:0] tag;
  } t_riscv_fetch_resp;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } t_ifetch_mem_state;

  function automatic logic fetch_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/riscv_i32_ifetch_mem_adapter.sv
// Single-outstanding word fetch adapter between the fetch/debug stage and a req/ack
// instruction memory; handles misalignment, flush epochs and memory timeout.
//
// state   | meaning
// ST_IDLE | no read in flight, waiting for a request
// ST_WAIT | mem_req high, waiting for mem_ack or timeout
// ST_RESP | response valid this cycle; may accept the next request
module riscv_i32_ifetch_mem_adapter
  import riscv_i32_ifetch_mem_adapter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ifetch_req__valid,
  input  logic [31:0] ifetch_req__address,
  input  logic        ifetch_req__sequential,
  input  logic [2:0]  ifetch_req__mode,
  input  logic        ifetch_req__flush,
  output logic        ifetch_resp__valid,
  output logic        ifetch_resp__debug,
  output logic [31:0] ifetch_resp__data,
  output logic [2:0]  ifetch_resp__mode,
  output logic        ifetch_resp__error,
  output logic [1:0]  ifetch_resp__tag,
  output logic        mem_req,
  output logic [31:0] mem_address,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  t_riscv_fetch_req                 req;
  t_riscv_fetch_resp                resp_q;
  t_ifetch_mem_state                state;
  logic [RISCV_FETCH_TAG_W-1:0]     tag;
  logic [RISCV_FETCH_TAG_W-1:0]     accept_tag;
  logic [RISCV_FETCH_TAG_W-1:0]     req_tag;
  logic [2:0]                       req_mode;
  logic [TO_W-1:0]                  to_cnt;
  logic                             discard;
  logic                             flush_in_wait;
  logic                             discard_now;
  logic                             unused_sequential;

  assign req = {ifetch_req__valid, ifetch_req__address, ifetch_req__sequential,
                ifetch_req__mode, ifetch_req__flush};

  // Addresses are always sent in full, so the sequential hint carries no information here.
  assign unused_sequential = req.sequential;

  assign accept_tag    = req.flush ? tag + 1'b1 : tag;
  assign flush_in_wait = req.flush && !discard;
  assign discard_now   = discard || req.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      tag         <= '0;
      req_tag     <= '0;
      req_mode    <= '0;
      to_cnt      <= '0;
      discard     <= 1'b0;
      mem_req     <= 1'b0;
      mem_address <= '0;
      resp_q      <= '0;
    end else begin
      resp_q.valid <= 1'b0;
      resp_q.data  <= '0;
      resp_q.error <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (req.valid) begin
            tag <= accept_tag;
            if (fetch_misaligned(req.address)) begin
              resp_q.valid <= 1'b1;
              resp_q.error <= 1'b1;
              resp_q.mode  <= req.mode;
              resp_q.tag   <= accept_tag;
              state        <= ST_RESP;
            end else begin
              mem_req     <= 1'b1;
              mem_address <= {req.address[31:2], 2'b00};
              req_mode    <= req.mode;
              req_tag     <= accept_tag;
              to_cnt      <= '0;
              state       <= ST_WAIT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A flush held over several cycles opens only one new epoch.
          if (flush_in_wait) tag <= tag + 1'b1;
          if (mem_ack || to_cnt == TO_LAST) begin
            mem_req <= 1'b0;
            discard <= 1'b0;
            if (discard_now) begin
              state <= ST_IDLE;
            end else begin
              resp_q.valid <= 1'b1;
              resp_q.mode  <= req_mode;
              resp_q.tag   <= req_tag;
              state        <= ST_RESP;
              // Bus-error data is passed through; a timeout has no data to return.
              if (mem_ack) begin
                resp_q.data  <= mem_rdata;
                resp_q.error <= mem_error;
              end else begin
                resp_q.error <= 1'b1;
              end
            end
          end else begin
            to_cnt  <= to_cnt + 1'b1;
            discard <= discard_now;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ifetch_resp__valid = resp_q.valid;
  assign ifetch_resp__debug = resp_q.debug;
  assign ifetch_resp__data  = resp_q.data;
  assign ifetch_resp__mode  = resp_q.mode;
  assign ifetch_resp__error = resp_q.error;
  assign ifetch_resp__tag   = resp_q.tag;

endmodule

// File: tb/tb_riscv_i32_ifetch_mem_adapter.sv
// Directed bench for the ifetch memory adapter: vector table plus hand-written
// flush, timeout and reset sequences.
module tb_riscv_i32_ifetch_mem_adapter;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_address;
  logic        req_sequential;
  logic [2:0]  req_mode;
  logic        req_flush;
  logic        resp_valid;
  logic        resp_debug;
  logic [31:0] resp_data;
  logic [2:0]  resp_mode;
  logic        resp_error;
  logic [1:0]  resp_tag;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_error;

  int n_pass  = 0;
  int n_total = 0;

  riscv_i32_ifetch_mem_adapter #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .ifetch_req__valid      (req_valid),
    .ifetch_req__address    (req_address),
    .ifetch_req__sequential (req_sequential),
    .ifetch_req__mode       (req_mode),
    .ifetch_req__flush      (req_flush),
    .ifetch_resp__valid     (resp_valid),
    .ifetch_resp__debug     (resp_debug),
    .ifetch_resp__data      (resp_data),
    .ifetch_resp__mode      (resp_mode),
    .ifetch_resp__error     (resp_error),
    .ifetch_resp__tag       (resp_tag),
    .mem_req                (mem_req),
    .mem_address            (mem_address),
    .mem_ack                (mem_ack),
    .mem_rdata              (mem_rdata),
    .mem_error              (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic        flush;
    logic [2:0]  mode;
    logic        ack;
    logic [31:0] rdata;
    logic        merr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_err;
    logic [1:0]  e_tag;
    logic [2:0]  e_mode;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic f, input logic [2:0] m,
                       input logic ack, input logic [31:0] rd, input logic me);
    req_valid   = v;
    req_address = a;
    req_flush   = f;
    req_mode    = m;
    mem_ack     = ack;
    mem_rdata   = rd;
    mem_error   = me;
  endtask

  task automatic chk_resp(input string name, input logic [31:0] d, input logic e,
                          input logic [1:0] t, input logic [2:0] m);
    chk({name, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({name, "_data"}, resp_data, d);
    chk({name, "_err"}, {31'd0, resp_error}, {31'd0, e});
    chk({name, "_tag"}, {30'd0, resp_tag}, {30'd0, t});
    chk({name, "_mode"}, {29'd0, resp_mode}, {29'd0, m});
  endtask

  initial begin
    int drop_at;
    req_sequential = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;

    //         v  addr           f  m  ack rdata          me  req addr          val data          err tag mode
    vecs[0]  = '{1, 32'h100,      0, 3, 0, 32'h0,         0,  1, 32'h100,      0, 32'h0,         0, 0, 0};
    vecs[1]  = '{1, 32'h100,      0, 3, 1, 32'h13,        0,  0, 32'h0,        1, 32'h13,        0, 0, 3};
    vecs[2]  = '{1, 32'h102,      0, 1, 0, 32'h0,         0,  0, 32'h0,        1, 32'h0,         1, 0, 1};
    vecs[3]  = '{0, 32'h0,        0, 0, 0, 32'h0,         0,  0, 32'h0,        0, 32'h0,         0, 0, 0};
    vecs[4]  = '{1, 32'h104,      0, 2, 0, 32'h0,         0,  1, 32'h104,      0, 32'h0,         0, 0, 0};
    vecs[5]  = '{1, 32'h104,      0, 2, 1, 32'hAAAA5555,  0,  0, 32'h0,        1, 32'hAAAA5555,  0, 0, 2};
    vecs[6]  = '{1, 32'h108,      0, 5, 0, 32'h0,         0,  1, 32'h108,      0, 32'h0,         0, 0, 0};
    vecs[7]  = '{1, 32'h108,      0, 5, 1, 32'h1234,      1,  0, 32'h0,        1, 32'h1234,      1, 0, 5};
    vecs[8]  = '{0, 32'h0,        0, 0, 0, 32'h0,         0,  0, 32'h0,        0, 32'h0,         0, 0, 0};
    vecs[9]  = '{1, 32'h10F,      0, 4, 0, 32'h0,         0,  0, 32'h0,        1, 32'h0,         1, 0, 4};
    vecs[10] = '{0, 32'h0,        0, 0, 0, 32'h0,         0,  0, 32'h0,        0, 32'h0,         0, 0, 0};
    vecs[11] = '{1, 32'hFFFFFFFC, 0, 7, 0, 32'h0,         0,  1, 32'hFFFFFFFC, 0, 32'h0,         0, 0, 0};
    vecs[12] = '{0, 32'h0,        0, 7, 1, 32'hFFFFFFFF,  0,  0, 32'h0,        1, 32'hFFFFFFFF,  0, 0, 7};
    vecs[13] = '{0, 32'h0,        0, 0, 1, 32'h5,         0,  0, 32'h0,        0, 32'h0,         0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_tag", {30'd0, resp_tag}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].flush, vecs[i].mode,
            vecs[i].ack, vecs[i].rdata, vecs[i].merr);
      tick();
      chk($sformatf("v%0d_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_valid", i), {31'd0, resp_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_debug", i), {31'd0, resp_debug}, 32'd0);
      if (vecs[i].e_req)
        chk($sformatf("v%0d_maddr", i), mem_address, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_data", i), resp_data, vecs[i].e_data);
        chk($sformatf("v%0d_err", i), {31'd0, resp_error}, {31'd0, vecs[i].e_err});
        chk($sformatf("v%0d_tag", i), {30'd0, resp_tag}, {30'd0, vecs[i].e_tag});
        chk($sformatf("v%0d_mode", i), {29'd0, resp_mode}, {29'd0, vecs[i].e_mode});
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Flush while the read is in flight: result discarded, epoch advances to 1.
    drive(1, 32'h200, 0, 1, 0, 0, 0);
    tick();
    chk("fl_req", {31'd0, mem_req}, 32'd1);
    chk("fl_maddr", mem_address, 32'h200);
    drive(1, 32'h200, 1, 1, 0, 0, 0);
    tick();
    chk("fl_req_held", {31'd0, mem_req}, 32'd1);
    drive(0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    tick();
    chk("fl_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("fl_req_drop", {31'd0, mem_req}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("fl_no_resp2", {31'd0, resp_valid}, 32'd0);
    drive(1, 32'h204, 0, 2, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h77, 0);
    tick();
    chk_resp("fl_next", 32'h77, 0, 2'd1, 3'd2);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Flush on an accepted request: the request carries the new epoch.
    drive(1, 32'h208, 1, 3, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h99, 0);
    tick();
    chk_resp("acc_flush", 32'h99, 0, 2'd2, 3'd3);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Timeout: never ack, expect mem_req to fall after 16 WAIT cycles.
    drive(1, 32'h300, 0, 6, 0, 0, 0);
    tick();
    chk("to_req", {31'd0, mem_req}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drop_at = 0;
    for (int i = 1; i <= 40 && drop_at == 0; i++) begin
      tick();
      if (!mem_req) drop_at = i;
    end
    chk("to_cycles", drop_at, 32'd16);
    chk_resp("to", 32'h0, 1, 2'd2, 3'd6);
    tick();
    chk("to_one_resp", {31'd0, resp_valid}, 32'd0);
    tick();
    tick();
    drive(0, 0, 0, 0, 1, 32'hBAD, 0);
    tick();
    chk("to_late_ack", {31'd0, resp_valid}, 32'd0);
    chk("to_late_req", {31'd0, mem_req}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Ack arrives on the same cycle the timeout would fire: ack wins.
    drive(1, 32'h310, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (15) tick();
    chk("atk_req", {31'd0, mem_req}, 32'd1);
    chk("atk_valid", {31'd0, resp_valid}, 32'd0);
    drive(0, 0, 0, 0, 1, 32'h4242, 0);
    tick();
    chk_resp("atk", 32'h4242, 0, 2'd2, 3'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Asynchronous reset in the middle of a read.
    drive(1, 32'h400, 0, 2, 0, 0, 0);
    tick();
    chk("rw_req", {31'd0, mem_req}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_req_async", {31'd0, mem_req}, 32'd0);
    chk("rw_tag_async", {30'd0, resp_tag}, 32'd0);
    chk("rw_valid_async", {31'd0, resp_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 1, 32'h66, 0);
    tick();
    chk("rw_stale_ack", {31'd0, resp_valid}, 32'd0);
    drive(1, 32'h404, 0, 4, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h88, 0);
    tick();
    chk_resp("rw_after", 32'h88, 0, 2'd0, 3'd4);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
